// File: rtl/mem_arbiter_pkg.sv
// Shared cpu definitions for the memory arbiter.
// State encoding and port-select constants.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/arb_req_latch.sv
// Holds the fields of the granted request for the
// lifetime of the single outstanding transaction.
module arb_req_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        port_i,
  input  logic        wr_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        port_o,
  output logic        wr_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o
);

  logic        port_q, port_d;
  logic        wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  always_comb begin
    port_d  = port_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (load_i) begin
      port_d  = port_i;
      wr_d    = wr_i;
      wstrb_d = wstrb_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q  <= 1'b0;
      wr_q    <= 1'b0;
      wstrb_q <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      port_q  <= port_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign port_o  = port_q;
  assign wr_o    = wr_q;
  assign wstrb_o = wstrb_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and memory-stage ports onto one
// memory bus, one transaction in flight at a time.
module mem_arbiter #(
  parameter int DATA_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        i_stall,
  output logic        d_stall,
  output logic        longest_stall
);

  import mem_arbiter_pkg::*;

  arb_state_e  state_q, state_d;
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic        inst_ok_q, inst_ok_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic        inst_go, data_go;
  logic        sel_data, grant, complete;
  logic        req_wr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr, req_wdata;
  logic        lat_port, lat_wr;
  logic [3:0]  lat_wstrb;
  logic [31:0] lat_addr, lat_wdata;

  // Stalls are masked in reset so the hazard unit never sees stale requests.
  assign i_stall = ~rst & inst_req & ~inst_done_q & ~inst_ok_q;
  assign d_stall = ~rst & data_req & ~data_done_q & ~data_ok_q;
  assign longest_stall = i_stall | d_stall;

  always_comb begin
    inst_go   = inst_req & ~inst_done_q;
    data_go   = data_req & ~data_done_q;
    sel_data  = data_go & ((DATA_PRIO != 0) | ~inst_go);
    grant     = (state_q == IDLE) & (inst_go | data_go);
    req_wr    = sel_data & data_wr;
    req_wstrb = sel_data ? data_wstrb : 4'h0;
    req_addr  = sel_data ? data_addr : inst_addr;
    req_wdata = sel_data ? data_wdata : 32'h0;
  end

  arb_req_latch u_req_latch (
    .clk     (clk),
    .rst     (rst),
    .load_i  (grant),
    .port_i  (sel_data ? PORT_DATA : PORT_INST),
    .wr_i    (req_wr),
    .wstrb_i (req_wstrb),
    .addr_i  (req_addr),
    .wdata_i (req_wdata),
    .port_o  (lat_port),
    .wr_o    (lat_wr),
    .wstrb_o (lat_wstrb),
    .addr_o  (lat_addr),
    .wdata_o (lat_wdata)
  );

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) state_d = ADDR;
      end
      ADDR: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inst_ok_d    = complete & (lat_port == PORT_INST);
    data_ok_d    = complete & (lat_port == PORT_DATA);
    inst_rdata_d = inst_ok_d ? mem_rdata : inst_rdata_q;
    data_rdata_d = (data_ok_d & ~lat_wr) ? mem_rdata : data_rdata_q;
    // Done flags hold off reissue until the whole pipeline unfreezes.
    inst_done_d  = longest_stall ? inst_done_q : 1'b0;
    data_done_d  = longest_stall ? data_done_q : 1'b0;
    if (inst_ok_d) inst_done_d = 1'b1;
    if (data_ok_d) data_done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign mem_req    = (state_q == ADDR);
  assign mem_wr     = lat_wr;
  assign mem_wstrb  = lat_wstrb;
  assign mem_addr   = lat_addr;
  assign mem_wdata  = lat_wdata;
  assign inst_ok    = inst_ok_q;
  assign data_ok    = data_ok_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model
// compared every cycle, plus hand-computed checkpoints.
module tb_mem_arbiter;

  localparam int DATA_PRIO = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_ok, data_ok;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;
  logic        i_stall, d_stall, longest_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_PRIO(DATA_PRIO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_ok(data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .i_stall(i_stall), .d_stall(d_stall),
    .longest_stall(longest_stall)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Model: one transaction record, whether its address was accepted,
  // per-port done/ok flags and read-data registers.
  typedef struct packed {
    logic        act;
    logic        acc;
    logic        port;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        idone;
    logic        ddone;
    logic        iok;
    logic        dok;
    logic [31:0] ird;
    logic [31:0] drd;
  } mdl_t;

  mdl_t m;

  function automatic logic ex_is(mdl_t s);
    return !rst && inst_req && !s.idone && !s.iok;
  endfunction

  function automatic logic ex_ds(mdl_t s);
    return !rst && data_req && !s.ddone && !s.dok;
  endfunction

  function automatic mdl_t step_model(mdl_t s);
    mdl_t n = s;
    logic busy, fin, ig, dg;
    busy  = ex_is(s) || ex_ds(s);
    fin   = s.act && mem_data_ok && (s.acc || mem_addr_ok);
    n.iok = fin && !s.port;
    n.dok = fin && s.port;
    if (!busy) begin
      n.idone = 1'b0;
      n.ddone = 1'b0;
    end
    if (fin) begin
      if (!s.port) begin
        n.ird   = mem_rdata;
        n.idone = 1'b1;
      end else begin
        n.ddone = 1'b1;
        if (!s.wr) n.drd = mem_rdata;
      end
      n.act = 1'b0;
      n.acc = 1'b0;
    end else if (s.act) begin
      if (mem_addr_ok) n.acc = 1'b1;
    end else begin
      ig = inst_req && !s.idone;
      dg = data_req && !s.ddone;
      if (ig || dg) begin
        n.act   = 1'b1;
        n.acc   = 1'b0;
        n.port  = dg && (DATA_PRIO != 0 || !ig);
        n.wr    = n.port ? data_wr : 1'b0;
        n.wstrb = n.port ? data_wstrb : 4'h0;
        n.addr  = n.port ? data_addr : inst_addr;
        n.wdata = n.port ? data_wdata : 32'h0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= step_model(m);
  end

  always @(negedge clk) begin
    chk("cmp_mem_req", mem_req, m.act && !m.acc);
    if (m.act && !m.acc) begin
      chk("cmp_mem_addr", mem_addr, m.addr);
      chk("cmp_mem_wr", mem_wr, m.wr);
      chk("cmp_mem_wstrb", mem_wstrb, m.wstrb);
      chk("cmp_mem_wdata", mem_wdata, m.wdata);
    end
    chk("cmp_inst_ok", inst_ok, m.iok);
    chk("cmp_data_ok", data_ok, m.dok);
    chk("cmp_inst_rdata", inst_rdata, m.ird);
    chk("cmp_data_rdata", data_rdata, m.drd);
    chk("cmp_i_stall", i_stall, ex_is(m));
    chk("cmp_d_stall", d_stall, ex_ds(m));
    chk("cmp_longest", longest_stall, ex_is(m) || ex_ds(m));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mem();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  task automatic idle(input int n);
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
    clr_mem();
    repeat (n) step();
  endtask

  initial begin
    rst        = 1'b1;
    inst_req   = 1'b1;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    inst_addr  = 32'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    clr_mem();

    // Reset: outputs cleared, stalls masked despite requests.
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_inst_ok", inst_ok, 1'b0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_longest", longest_stall, 1'b0);
    step();
    rst = 1'b0;
    idle(2);

    // Fetch alone; data_ok follows addr_ok by one cycle.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk("t1_c0_istall", i_stall, 1'b1);
    chk("t1_c0_memreq", mem_req, 1'b0);
    step();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("t1_c1_memreq", mem_req, 1'b1);
    chk("t1_c1_addr", mem_addr, 32'hBFC00000);
    chk("t1_c1_istall", i_stall, 1'b1);
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h3C080001;
    @(negedge clk);
    chk("t1_c2_istall", i_stall, 1'b1);
    chk("t1_c2_ok", inst_ok, 1'b0);
    step();
    clr_mem();
    @(negedge clk);
    chk("t1_c3_ok", inst_ok, 1'b1);
    chk("t1_c3_rdata", inst_rdata, 32'h3C080001);
    chk("t1_c3_istall", i_stall, 1'b0);
    step();
    inst_req = 1'b0;
    @(negedge clk);
    chk("t1_c4_ok", inst_ok, 1'b0);
    chk("t1_c4_rdata", inst_rdata, 32'h3C080001);
    idle(2);

    // Simultaneous requests: data first, then fetch.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00004;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h80001000;
    for (int c = 0; c < 7; c++) begin
      mem_addr_ok = (c == 1 || c == 4);
      mem_data_ok = (c == 2 || c == 5);
      mem_rdata   = (c == 2) ? 32'h11112222 :
                    (c == 5) ? 32'h3C080002 : 32'h0;
      @(negedge clk);
      chk("t2_longest", longest_stall, c < 6);
      if (c == 1) begin
        chk("t2_c1_memreq", mem_req, 1'b1);
        chk("t2_c1_addr", mem_addr, 32'h80001000);
      end
      if (c == 3) begin
        chk("t2_c3_dok", data_ok, 1'b1);
        chk("t2_c3_drd", data_rdata, 32'h11112222);
        chk("t2_c3_iok", inst_ok, 1'b0);
      end
      if (c == 4) chk("t2_c4_addr", mem_addr, 32'hBFC00004);
      if (c == 6) begin
        chk("t2_c6_iok", inst_ok, 1'b1);
        chk("t2_c6_ird", inst_rdata, 32'h3C080002);
      end
      step();
    end
    idle(2);

    // Partial write; combined addr_ok/data_ok cycle.
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'h3;
    data_addr  = 32'h80000004;
    data_wdata = 32'hDEADBEEF;
    step();
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFEF00D;
    @(negedge clk);
    chk("t3_memreq", mem_req, 1'b1);
    chk("t3_wr", mem_wr, 1'b1);
    chk("t3_wstrb", mem_wstrb, 4'h3);
    chk("t3_addr", mem_addr, 32'h80000004);
    chk("t3_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    clr_mem();
    @(negedge clk);
    chk("t3_dok", data_ok, 1'b1);
    chk("t3_drd_kept", data_rdata, 32'h11112222);
    step();
    idle(2);

    // Slow slave; request dropped mid-flight; lone data_ok in ADDR.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00008;
    for (int c = 1; c <= 8; c++) begin
      step();
      inst_req    = (c < 3);
      mem_addr_ok = (c == 5);
      mem_data_ok = (c == 3 || c == 7);
      mem_rdata   = (c == 7) ? 32'h3C080004 : 32'h0;
      @(negedge clk);
      if (c <= 5) begin
        chk("t4_memreq_hold", mem_req, 1'b1);
        chk("t4_addr_hold", mem_addr, 32'hBFC00008);
      end else begin
        chk("t4_memreq_low", mem_req, 1'b0);
      end
      chk("t4_ok_time", inst_ok, c == 8);
    end
    chk("t4_ird", inst_rdata, 32'h3C080004);
    step();
    idle(2);

    // Held fetch after ok while data stalls: no reissue.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0000C;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h80002000;
      end
      mem_addr_ok = (c == 1 || c == 6);
      mem_data_ok = (c == 2 || c == 7);
      mem_rdata   = (c == 2) ? 32'h3C080005 :
                    (c == 7) ? 32'h55667788 : 32'h0;
      @(negedge clk);
      if (c == 3) chk("t5_iok", inst_ok, 1'b1);
      if (c >= 4 && c <= 8) chk("t5_no_istall", i_stall, 1'b0);
      if (c >= 4 && c <= 6) chk("t5_daddr", mem_addr, 32'h80002000);
      if (c >= 7 && c <= 8) chk("t5_memreq_low", mem_req, 1'b0);
      if (c == 8) begin
        chk("t5_dok", data_ok, 1'b1);
        chk("t5_drd", data_rdata, 32'h55667788);
        chk("t5_longest", longest_stall, 1'b0);
      end
      if (c == 9) begin
        chk("t5_done_clr", i_stall, 1'b1);
        inst_req = 1'b0;
        data_req = 1'b0;
      end
    end
    step();
    idle(2);

    // Reset during DATA, then a late data_ok.
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h80003000;
    step();
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    data_req    = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_memreq", mem_req, 1'b0);
    chk("t6_dok", data_ok, 1'b0);
    chk("t6_drd", data_rdata, 32'h0);
    chk("t6_ird", inst_rdata, 32'h0);
    step();
    rst = 1'b0;
    step();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h99999999;
    step();
    clr_mem();
    @(negedge clk);
    chk("t6_late_dok", data_ok, 1'b0);
    chk("t6_late_drd", data_rdata, 32'h0);
    chk("t6_late_memreq", mem_req, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
